// File: rtl/maniac_input_conditioner.sv
// rtl/maniac_input_conditioner.sv - synchroniser, debounce FSM, edge pulses and sticky event flags per input channel
module maniac_input_conditioner #(
  parameter int N_IN      = 4,
  parameter int DB_CYCLES = 320000,
  parameter int CNT_W     = 19
) (
  input  logic            clk_32,
  input  logic            rst_n,
  input  logic [N_IN-1:0] raw_in,
  output logic [N_IN-1:0] level,
  output logic [N_IN-1:0] rise,
  output logic [N_IN-1:0] fall,
  output logic [N_IN-1:0] evt_pending,
  input  logic [N_IN-1:0] evt_ack
);

  typedef enum logic {
    ST_STABLE   = 1'b0,
    ST_CHANGING = 1'b1
  } state_t;

  // Last count value before a change is accepted; commit happens on the edge that sees it.
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DB_CYCLES - 1);

  logic [N_IN-1:0]  sync1_q, sync1_d;
  logic [N_IN-1:0]  sync2_q, sync2_d;
  logic [N_IN-1:0]  level_q, level_d;
  logic [N_IN-1:0]  rise_q, rise_d;
  logic [N_IN-1:0]  fall_q, fall_d;
  logic [N_IN-1:0]  pend_q, pend_d;
  state_t           state_q [N_IN];
  state_t           state_d [N_IN];
  logic [CNT_W-1:0] cnt_q   [N_IN];
  logic [CNT_W-1:0] cnt_d   [N_IN];

  // Two-flop synchroniser; only sync2 feeds the debounce logic.
  always_comb begin
    sync1_d = raw_in;
    sync2_d = sync1_q;
  end

  // Per-channel debounce: any return to the current level before commit restarts the count.
  always_comb begin
    level_d = level_q;
    rise_d  = '0;
    fall_d  = '0;
    for (int i = 0; i < N_IN; i++) begin
      state_d[i] = state_q[i];
      cnt_d[i]   = cnt_q[i];
      if (state_q[i] == ST_STABLE) begin
        if (sync2_q[i] != level_q[i]) begin
          state_d[i] = ST_CHANGING;
          cnt_d[i]   = CNT_W'(1);
        end else begin
          cnt_d[i]   = '0;
        end
      end else begin
        if (sync2_q[i] == level_q[i]) begin
          state_d[i] = ST_STABLE;
          cnt_d[i]   = '0;
        end else if (cnt_q[i] == CNT_MAX) begin
          level_d[i] = sync2_q[i];
          rise_d[i]  = sync2_q[i];
          fall_d[i]  = ~sync2_q[i];
          state_d[i] = ST_STABLE;
          cnt_d[i]   = '0;
        end else begin
          cnt_d[i]   = cnt_q[i] + CNT_W'(1);
        end
      end
    end
  end

  // Sticky event flag: a rise in the same cycle as an ack keeps the flag set.
  always_comb begin
    pend_d = (pend_q & ~evt_ack) | rise_q;
  end

  // State register; reset wipes any partial debounce immediately.
  always_ff @(posedge clk_32 or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= '0;
      sync2_q <= '0;
      level_q <= '0;
      rise_q  <= '0;
      fall_q  <= '0;
      pend_q  <= '0;
      for (int i = 0; i < N_IN; i++) begin
        state_q[i] <= ST_STABLE;
        cnt_q[i]   <= '0;
      end
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      level_q <= level_d;
      rise_q  <= rise_d;
      fall_q  <= fall_d;
      pend_q  <= pend_d;
      for (int i = 0; i < N_IN; i++) begin
        state_q[i] <= state_d[i];
        cnt_q[i]   <= cnt_d[i];
      end
    end
  end

  assign level       = level_q;
  assign rise        = rise_q;
  assign fall        = fall_q;
  assign evt_pending = pend_q;

endmodule

// File: tb/tb_maniac_input_conditioner.sv
// tb/tb_maniac_input_conditioner.sv - directed self-checking bench for maniac_input_conditioner
module tb_maniac_input_conditioner;

  logic       clk_32;
  logic       rst_n;
  logic [3:0] raw_in;
  logic [3:0] level;
  logic [3:0] rise;
  logic [3:0] fall;
  logic [3:0] evt_pending;
  logic [3:0] evt_ack;

  int tests_run;
  int tests_failed;

  maniac_input_conditioner #(
    .N_IN      (4),
    .DB_CYCLES (8),
    .CNT_W     (4)
  ) dut (
    .clk_32      (clk_32),
    .rst_n       (rst_n),
    .raw_in      (raw_in),
    .level       (level),
    .rise        (rise),
    .fall        (fall),
    .evt_pending (evt_pending),
    .evt_ack     (evt_ack)
  );

  initial clk_32 = 1'b0;
  always #5 clk_32 = ~clk_32;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk_32);
    #1;
  endtask

  task automatic test_reset();
    rst_n   = 1'b0;
    raw_in  = 4'hF;
    evt_ack = 4'h0;
    #1;
    for (int t = 0; t < 5; t++) begin
      tick();
      tests_run++;
      if ({level, rise, fall, evt_pending} !== 16'h0000) begin
        tests_failed++;
        $display("FAIL reset_hold cycle %0d: level=%h rise=%h fall=%h pend=%h, required all 0",
                 t, level, rise, fall, evt_pending);
      end
    end
    raw_in = 4'h0;
    tick();
    tick();
    rst_n = 1'b1;
    for (int t = 0; t < 12; t++) tick();
    tests_run++;
    if ({level, rise, fall, evt_pending} !== 16'h0000) begin
      tests_failed++;
      $display("FAIL reset_release_idle: level=%h rise=%h fall=%h pend=%h, required all 0",
               level, rise, fall, evt_pending);
    end
  endtask

  task automatic test_rise();
    raw_in[1] = 1'b1;
    for (int e = 0; e < 9; e++) begin
      tick();
      tests_run++;
      if (level[1] !== 1'b0 || rise[1] !== 1'b0) begin
        tests_failed++;
        $display("FAIL rise_early edge %0d: level=%h rise=%h, required level[1]=0 rise[1]=0",
                 e, level, rise);
      end
    end
    tick();
    tests_run++;
    if (rise !== 4'b0010 || level !== 4'b0010 || fall !== 4'b0000 || evt_pending !== 4'b0000) begin
      tests_failed++;
      $display("FAIL rise_commit: level=%h rise=%h fall=%h pend=%h, required 2 2 0 0",
               level, rise, fall, evt_pending);
    end
    tick();
    tests_run++;
    if (rise !== 4'b0000 || level !== 4'b0010 || evt_pending !== 4'b0010) begin
      tests_failed++;
      $display("FAIL rise_after: level=%h rise=%h pend=%h, required 2 0 2",
               level, rise, evt_pending);
    end
  endtask

  task automatic test_glitch();
    int bad;
    bad = 0;
    raw_in[2] = 1'b1;
    for (int t = 0; t < 25; t++) begin
      if (t == 5) raw_in[2] = 1'b0;
      tick();
      if (level[2] !== 1'b0 || rise[2] !== 1'b0 || fall[2] !== 1'b0 || evt_pending[2] !== 1'b0) bad++;
    end
    tests_run++;
    if (bad != 0) begin
      tests_failed++;
      $display("FAIL glitch_ch2: %0d cycles with ch2 activity, required 0", bad);
    end
  endtask

  task automatic test_bounce();
    int first;
    int nrise;
    first = -1;
    nrise = 0;
    raw_in[3] = 1'b1;
    for (int t = 0; t < 3; t++) begin tick(); if (rise[3]) nrise++; end
    raw_in[3] = 1'b0;
    for (int t = 0; t < 3; t++) begin tick(); if (rise[3]) nrise++; end
    raw_in[3] = 1'b1;
    for (int t = 1; t <= 20; t++) begin
      tick();
      if (rise[3] === 1'b1) begin
        nrise++;
        if (first < 0) first = t;
      end
    end
    tests_run++;
    if (first != 10) begin
      tests_failed++;
      $display("FAIL bounce_latency: rise[3] at cycle %0d, required 10", first);
    end
    tests_run++;
    if (nrise != 1) begin
      tests_failed++;
      $display("FAIL bounce_count: %0d rise pulses, required 1", nrise);
    end
    tests_run++;
    if (level !== 4'b1010 || evt_pending !== 4'b1010) begin
      tests_failed++;
      $display("FAIL bounce_state: level=%h pend=%h, required a a", level, evt_pending);
    end
  endtask

  task automatic test_ack_collision();
    raw_in[1] = 1'b0;
    for (int t = 0; t < 9; t++) tick();
    tick();
    tests_run++;
    if (fall !== 4'b0010 || rise !== 4'b0000 || level !== 4'b1000 || evt_pending !== 4'b1010) begin
      tests_failed++;
      $display("FAIL fall_commit: fall=%h rise=%h level=%h pend=%h, required 2 0 8 a",
               fall, rise, level, evt_pending);
    end
    evt_ack = 4'b0010;
    tick();
    evt_ack = 4'b0000;
    tests_run++;
    if (evt_pending !== 4'b1000) begin
      tests_failed++;
      $display("FAIL ack_clear: pend=%h, required 8", evt_pending);
    end
    evt_ack = 4'b0010;
    tick();
    evt_ack = 4'b0000;
    tests_run++;
    if (evt_pending !== 4'b1000 || level !== 4'b1000) begin
      tests_failed++;
      $display("FAIL ack_noop: pend=%h level=%h, required 8 8", evt_pending, level);
    end
    raw_in[1] = 1'b1;
    for (int t = 0; t < 9; t++) tick();
    tick();
    tests_run++;
    if (rise !== 4'b0010 || evt_pending !== 4'b1000) begin
      tests_failed++;
      $display("FAIL rearm_rise: rise=%h pend=%h, required 2 8", rise, evt_pending);
    end
    evt_ack = 4'b0010;
    tick();
    evt_ack = 4'b0000;
    tests_run++;
    if (evt_pending !== 4'b1010) begin
      tests_failed++;
      $display("FAIL set_wins: pend=%h, required a", evt_pending);
    end
    tick();
    tests_run++;
    if (evt_pending !== 4'b1010) begin
      tests_failed++;
      $display("FAIL pend_sticky: pend=%h, required a", evt_pending);
    end
    evt_ack = 4'b0010;
    tick();
    evt_ack = 4'b0000;
    tests_run++;
    if (evt_pending !== 4'b1000) begin
      tests_failed++;
      $display("FAIL late_ack_clear: pend=%h, required 8", evt_pending);
    end
  endtask

  task automatic test_reset_mid_count();
    raw_in[0] = 1'b1;
    for (int t = 0; t < 6; t++) tick();
    rst_n = 1'b0;
    #1;
    tests_run++;
    if ({level, rise, fall, evt_pending} !== 16'h0000) begin
      tests_failed++;
      $display("FAIL reset_async: level=%h rise=%h fall=%h pend=%h, required all 0",
               level, rise, fall, evt_pending);
    end
    tick();
    tick();
    rst_n = 1'b1;
    for (int t = 1; t <= 12; t++) begin
      tick();
      if (t < 10) begin
        tests_run++;
        if (rise !== 4'b0000 || level !== 4'b0000) begin
          tests_failed++;
          $display("FAIL post_reset_early cycle %0d: rise=%h level=%h, required 0 0", t, rise, level);
        end
      end else if (t == 10) begin
        tests_run++;
        if (rise !== 4'b1011 || level !== 4'b1011) begin
          tests_failed++;
          $display("FAIL post_reset_commit: rise=%h level=%h, required b b", rise, level);
        end
      end else if (t == 11) begin
        tests_run++;
        if (rise !== 4'b0000 || evt_pending !== 4'b1011) begin
          tests_failed++;
          $display("FAIL post_reset_pend: rise=%h pend=%h, required 0 b", rise, evt_pending);
        end
      end
    end
  endtask

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    rst_n        = 1'b0;
    raw_in       = 4'h0;
    evt_ack      = 4'h0;
    test_reset();
    test_rise();
    test_glitch();
    test_bounce();
    test_ack_collision();
    test_reset_mid_count();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
